// File: rtl/sdm_decim_pkg.sv
// Shared types and constants for the SDM decimation sequencer.
package sdm_decim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int FLUSH_CYC   = 2;
    localparam int FLUSH_CNT_W = 2;
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYC - 1);

endpackage

// File: rtl/sdm_ce_divider.sv
// Programmable-period strobe generator: chain_ce pulses once every div+1 cycles while run=1.
module sdm_ce_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             run,
    output logic             chain_ce
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // Period is captured only at start so live register writes cannot disturb a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load)
                div_q <= div_cfg;
            if (!run || cnt_q == div_q)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    assign chain_ce = run && (cnt_q == div_q);

endmodule

// File: rtl/sdm_decim_ctrl.sv
// Sequencer for the SDM averaging decimation chain: flush, settle-discard, stream out.
// Optional SDM_DECIM_STATS_EN adds saturating transfer/drop counters.
module sdm_decim_ctrl
    import sdm_decim_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int SETTLE_W = 8,
    parameter int DATA_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div_cfg,
    input  logic [SETTLE_W-1:0]      settle_cfg,
    output logic                     chain_rst,
    output logic                     chain_ce,
    input  logic                     chain_valid,
    input  logic signed [DATA_W-1:0] chain_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clr_overrun
`ifdef SDM_DECIM_STATS_EN
    ,
    output logic [31:0]              sample_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    state_t                     state_q, state_d;
    logic [FLUSH_CNT_W-1:0]     flush_q;
    logic [SETTLE_W-1:0]        settle_lat_q;
    logic [SETTLE_W-1:0]        settle_q;
    logic signed [DATA_W-1:0]   data_p0;
    logic                       vld_p0;
    logic                       overrun_q;

    logic start, div_run, accept, flush_done, settle_done, xfer, drop;

    assign flush_done  = (flush_q == FLUSH_LAST);
    assign settle_done = chain_valid && ((settle_q + SETTLE_W'(1)) == settle_lat_q);
    assign xfer        = vld_p0 && m_ready;
    assign drop        = accept && vld_p0 && !m_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = FLUSH;
            FLUSH:   if (!enable) state_d = IDLE;
                     else if (flush_done) state_d = (settle_lat_q == '0) ? RUN : SETTLE;
            SETTLE:  if (!enable) state_d = IDLE;
                     else if (settle_done) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chain_rst = 1'b0;
        busy      = 1'b0;
        div_run   = 1'b0;
        start     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE:   start = enable;
            FLUSH:  begin chain_rst = 1'b1; busy = 1'b1; end
            SETTLE: begin busy = 1'b1; div_run = 1'b1; end
            RUN:    begin busy = 1'b1; div_run = 1'b1; accept = chain_valid; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q      <= '0;
            settle_q     <= '0;
            settle_lat_q <= '0;
        end else begin
            if (start)
                settle_lat_q <= settle_cfg;
            flush_q <= (state_q == FLUSH) ? flush_q + FLUSH_CNT_W'(1) : '0;
            if (state_q != SETTLE)
                settle_q <= '0;
            else if (chain_valid)
                settle_q <= settle_q + SETTLE_W'(1);
        end
    end

    sdm_ce_divider #(.DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .div_cfg  (div_cfg),
        .run      (div_run),
        .chain_ce (chain_ce)
    );

    // Output stage: a held sample is never overwritten; a same-cycle transfer frees the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0   <= '0;
            vld_p0    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (accept && (!vld_p0 || m_ready)) begin
                data_p0 <= chain_data;
                vld_p0  <= 1'b1;
            end else if (xfer) begin
                vld_p0  <= 1'b0;
            end
            if (drop)
                overrun_q <= 1'b1;
            else if (clr_overrun)
                overrun_q <= 1'b0;
        end
    end

    assign m_valid = vld_p0;
    assign m_data  = data_p0;
    assign overrun = overrun_q;

`ifdef SDM_DECIM_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [31:0] sample_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (xfer)
                sample_cnt_q <= sat_inc32(sample_cnt_q);
            if (drop)
                drop_cnt_q <= sat_inc16(drop_cnt_q);
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sdm_decim_ctrl.sv
// Directed bench for sdm_decim_ctrl: vector table plus hand-written corner sequences.
module tb_sdm_decim_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst, enable, chain_valid, m_ready, clr_overrun;
    logic [15:0] div_cfg;
    logic [7:0]  settle_cfg;
    logic [15:0] chain_data;
    logic        chain_rst, chain_ce, m_valid, busy, overrun;
    logic [15:0] m_data;
`ifdef SDM_DECIM_STATS_EN
    logic [31:0] sample_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdm_decim_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .div_cfg     (div_cfg),
        .settle_cfg  (settle_cfg),
        .chain_rst   (chain_rst),
        .chain_ce    (chain_ce),
        .chain_valid (chain_valid),
        .chain_data  (chain_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef SDM_DECIM_STATS_EN
        ,
        .sample_cnt  (sample_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    typedef struct {
        logic        en;
        logic [15:0] div;
        logic [7:0]  settle;
        logic        cv;
        logic [15:0] cd;
        logic        rdy;
        logic        clr;
        logic        e_rst;
        logic        e_ce;
        logic        e_mv;
        logic [15:0] e_md;
        logic        e_busy;
        logic        e_ov;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic en, input logic [15:0] div, input logic [7:0] settle,
                                input logic cv, input logic [15:0] cd, input logic rdy,
                                input logic clr, input logic e_rst, input logic e_ce,
                                input logic e_mv, input logic [15:0] e_md, input logic e_busy,
                                input logic e_ov);
        vec_t v;
        v.en = en; v.div = div; v.settle = settle; v.cv = cv; v.cd = cd; v.rdy = rdy;
        v.clr = clr; v.e_rst = e_rst; v.e_ce = e_ce; v.e_mv = e_mv; v.e_md = e_md;
        v.e_busy = e_busy; v.e_ov = e_ov;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; chain_valid = 1'b0; chain_data = 16'h0000;
        m_ready = 1'b0; clr_overrun = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // en  div     set   cv cd        rdy clr | rst ce mv md       busy ov
        vecs[0]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  H, L, L, 16'h0000, H, L);
        vecs[1]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  H, L, L, 16'h0000, H, L);
        vecs[2]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[3]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[4]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[5]  = mk(H, 16'd3, 8'd0, L, 16'h0000, L, L,  L, H, L, 16'h0000, H, L);
        vecs[6]  = mk(H, 16'd7, 8'd9, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[7]  = mk(H, 16'd7, 8'd9, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[8]  = mk(H, 16'd7, 8'd9, L, 16'h0000, L, L,  L, L, L, 16'h0000, H, L);
        vecs[9]  = mk(H, 16'd7, 8'd9, L, 16'h0000, L, L,  L, H, L, 16'h0000, H, L);
        vecs[10] = mk(H, 16'd7, 8'd9, H, 16'h1234, L, L,  L, L, H, 16'h1234, H, L);
        vecs[11] = mk(H, 16'd7, 8'd9, H, 16'h5678, L, L,  L, L, H, 16'h1234, H, H);
        vecs[12] = mk(H, 16'd7, 8'd9, L, 16'h0000, L, H,  L, L, H, 16'h1234, H, L);
        vecs[13] = mk(H, 16'd7, 8'd9, H, 16'h0ABC, H, L,  L, H, H, 16'h0ABC, H, L);
        vecs[14] = mk(H, 16'd7, 8'd9, L, 16'h0000, H, L,  L, L, L, 16'h0ABC, H, L);
        vecs[15] = mk(H, 16'd7, 8'd9, H, 16'h8001, L, L,  L, L, H, 16'h8001, H, L);
        vecs[16] = mk(H, 16'd7, 8'd9, H, 16'h7FFF, L, H,  L, L, H, 16'h8001, H, H);
        vecs[17] = mk(H, 16'd7, 8'd9, L, 16'h0000, H, L,  L, H, L, 16'h8001, H, H);
        vecs[18] = mk(L, 16'd7, 8'd9, L, 16'h0000, L, L,  L, L, L, 16'h8001, L, H);
        vecs[19] = mk(L, 16'd7, 8'd9, H, 16'h1111, L, L,  L, L, L, 16'h8001, L, H);
        vecs[20] = mk(L, 16'd7, 8'd9, L, 16'h0000, L, H,  L, L, L, 16'h8001, L, L);

        div_cfg = 16'd0; settle_cfg = 8'd0;
        do_reset();
        chk1("reset chain_rst", chain_rst, 1'b0);
        chk1("reset chain_ce", chain_ce, 1'b0);
        chk1("reset m_valid", m_valid, 1'b0);
        chk16("reset m_data", m_data, 16'h0000);
        chk1("reset busy", busy, 1'b0);
        chk1("reset overrun", overrun, 1'b0);

        // Rate, overrun, simultaneous-transfer and stop behaviour from the table.
        for (int i = 0; i < 21; i++) begin
            enable = vecs[i].en; div_cfg = vecs[i].div; settle_cfg = vecs[i].settle;
            chain_valid = vecs[i].cv; chain_data = vecs[i].cd;
            m_ready = vecs[i].rdy; clr_overrun = vecs[i].clr;
            tick();
            chk1($sformatf("row%0d chain_rst", i), chain_rst, vecs[i].e_rst);
            chk1($sformatf("row%0d chain_ce", i), chain_ce, vecs[i].e_ce);
            chk1($sformatf("row%0d m_valid", i), m_valid, vecs[i].e_mv);
            chk16($sformatf("row%0d m_data", i), m_data, vecs[i].e_md);
            chk1($sformatf("row%0d busy", i), busy, vecs[i].e_busy);
            chk1($sformatf("row%0d overrun", i), overrun, vecs[i].e_ov);
        end

        // Settle discard: five samples dropped, sixth and seventh delivered.
        do_reset();
        div_cfg = 16'd1; settle_cfg = 8'd5; enable = 1'b1;
        tick();
        tick();
        tick();
        chk1("settle entry chain_rst", chain_rst, 1'b0);
        chk1("settle first cycle ce", chain_ce, 1'b0);
        tick();
        chk1("settle second cycle ce", chain_ce, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            chain_valid = 1'b1; chain_data = 16'(i); m_ready = 1'b0;
            tick();
            chain_valid = 1'b0;
            chk1($sformatf("settle sample%0d m_valid", i), m_valid, (i >= 6));
            if (i >= 6)
                chk16($sformatf("settle sample%0d m_data", i), m_data, 16'(i));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            chk1($sformatf("settle sample%0d drained", i), m_valid, 1'b0);
        end
        chk1("settle overrun", overrun, 1'b0);

        // Stop during SETTLE, then restart must flush again.
        do_reset();
        div_cfg = 16'd2; settle_cfg = 8'd3; enable = 1'b1;
        tick();
        tick();
        tick();
        chk1("stop pre busy", busy, 1'b1);
        chk1("stop pre chain_rst", chain_rst, 1'b0);
        enable = 1'b0;
        tick();
        chk1("stop busy", busy, 1'b0);
        chk1("stop chain_ce", chain_ce, 1'b0);
        tick();
        tick();
        chk1("stop idle chain_ce", chain_ce, 1'b0);
        enable = 1'b1;
        tick();
        chk1("restart chain_rst", chain_rst, 1'b1);
        chk1("restart busy", busy, 1'b1);
        tick();
        chk1("restart chain_rst 2", chain_rst, 1'b1);
        tick();
        chk1("restart released", chain_rst, 1'b0);

        // Reset in RUN with a pending sample and a sticky overrun.
        do_reset();
        div_cfg = 16'd0; settle_cfg = 8'd0; enable = 1'b1;
        tick();
        tick();
        tick();
        chk1("run div0 ce", chain_ce, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chain_valid = 1'b1; chain_data = 16'hA000 + 16'(i); m_ready = 1'b0;
            tick();
            chain_valid = 1'b0; m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        chain_valid = 1'b1; chain_data = 16'h00F0;
        tick();
        chain_data = 16'h00F1;
        tick();
        chain_valid = 1'b0;
        chk1("pre-rst m_valid", m_valid, 1'b1);
        chk16("pre-rst m_data", m_data, 16'h00F0);
        chk1("pre-rst overrun", overrun, 1'b1);
`ifdef SDM_DECIM_STATS_EN
        chk32("pre-rst sample_cnt", sample_cnt, 32'd3);
        chk32("pre-rst drop_cnt", {16'h0000, drop_cnt}, 32'd1);
`endif
        rst = 1'b1;
        tick();
        chk1("rst m_valid", m_valid, 1'b0);
        chk1("rst overrun", overrun, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk16("rst m_data", m_data, 16'h0000);
`ifdef SDM_DECIM_STATS_EN
        chk32("rst sample_cnt", sample_cnt, 32'd0);
`endif
        enable = 1'b0;
        rst = 1'b0;
        tick();
        chk1("post-rst idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
